md_unit_ctrl: RTL and testbench

- Multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and models multi-cycle mult/div latency with a countdown.
- Raises a stall request to the hazard logic when a D-stage MD-class instruction would collide with a busy unit.
- Serves mfhi/mflo reads and mthi/mtlo writes.

---
 rtl/md_unit_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_md_unit_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide sequencer for the E stage.
// Owns HI/LO, models mult/div latency with a countdown, requests D-stage stalls
// while the unit is busy, and serves mfhi/mflo/mthi/mtlo.
// Optional feature: define MD_MADD_EN to enable madd/maddu/msub/msubu (opcodes 9-12).
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_md_op,
  input  logic        e_valid,
  input  logic [31:0] e_rs_val,
  input  logic [31:0] e_rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        e_start,
  output logic        stall_md,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        pend_vld, pend_vld_nx;
  logic [63:0] pend_res, pend_res_nx;
  logic [31:0] hi_nx, lo_nx;
  logic        is_div;

  // Opcodes that launch a multi-cycle operation.
  function automatic logic op_is_start(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Full 64-bit {hi,lo} result of a start op; acc is the {hi,lo} at the start edge.
  // Signed division is done at 64 bits so 0x80000000 / -1 cannot overflow and
  // simply wraps to 0x80000000 in the low word. A zero divisor is replaced by 1
  // so the divider never sees it; that result is discarded at commit anyway.
  function automatic logic [63:0] md_result(input logic [3:0]  op,
                                            input logic [31:0] rs,
                                            input logic [31:0] rt,
                                            input logic [63:0] acc);
    logic signed [63:0] rs_s;
    logic signed [63:0] rt_s;
    logic signed [63:0] dvs_s;
    logic signed [63:0] prod_s;
    logic signed [63:0] quo_s;
    logic signed [63:0] rem_s;
    logic        [63:0] prod_u;
    logic        [31:0] rt_nz;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic        [63:0] res;
    rt_nz  = (rt == 32'd0) ? 32'd1 : rt;
    rs_s   = {{32{rs[31]}}, rs};
    rt_s   = {{32{rt[31]}}, rt};
    dvs_s  = {{32{rt_nz[31]}}, rt_nz};
    prod_s = rs_s * rt_s;
    prod_u = {32'd0, rs} * {32'd0, rt};
    quo_s  = rs_s / dvs_s;
    rem_s  = rs_s % dvs_s;
    quo_u  = rs / rt_nz;
    rem_u  = rs % rt_nz;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {rem_s[31:0], quo_s[31:0]};
      OP_DIVU:  res = {rem_u, quo_u};
`ifdef MD_MADD_EN
      OP_MADD:  res = acc + prod_s;
      OP_MADDU: res = acc + prod_u;
      OP_MSUB:  res = acc - prod_s;
      OP_MSUBU: res = acc - prod_u;
`endif
      default:  res = acc;
    endcase
    return res;
  endfunction

  assign busy     = (state == S_RUN);
  assign e_start  = e_valid & op_is_start(e_md_op);
  assign stall_md = d_is_md & (busy | e_start);
  assign is_div   = (e_md_op == OP_DIV) || (e_md_op == OP_DIVU);

  // HI/LO read port for mfhi/mflo, driven regardless of e_valid.
  always_comb begin
    md_out = 32'd0;
    if (e_md_op == OP_MFHI) md_out = hi;
    else if (e_md_op == OP_MFLO) md_out = lo;
  end

  // Next-state: launch in IDLE, count down in RUN, commit on the last busy cycle.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pend_vld_nx = pend_vld;
    pend_res_nx = pend_res;
    hi_nx       = hi;
    lo_nx       = lo;
    case (state)
      S_IDLE: begin
        if (e_start) begin
          pend_res_nx = md_result(e_md_op, e_rs_val, e_rt_val, {hi, lo});
          pend_vld_nx = !(is_div && (e_rt_val == 32'd0));
          cnt_nx      = is_div ? DIV_CNT : MULT_CNT;
          state_nx    = S_RUN;
        end else if (e_valid && (e_md_op == OP_MTHI)) begin
          hi_nx = e_rs_val;
        end else if (e_valid && (e_md_op == OP_MTLO)) begin
          lo_nx = e_rs_val;
        end
      end
      S_RUN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx    = S_IDLE;
          pend_vld_nx = 1'b0;
          if (pend_vld) begin
            hi_nx = pend_res[63:32];
            lo_nx = pend_res[31:0];
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Control state and architectural HI/LO; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      pend_vld <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pend_vld <= pend_vld_nx;
      hi       <= hi_nx;
      lo       <= lo_nx;
    end
  end

  // Pending result holding register; only meaningful while pend_vld is set.
  always_ff @(posedge clk) begin
    pend_res <= pend_res_nx;
  end

`ifndef SYNTHESIS
  // Report start requests that arrive while busy; the hardware drops them.
  always @(posedge clk) begin
    if (!reset && busy && e_start)
      $warning("md_unit_ctrl: start op %0d ignored while busy", e_md_op);
  end
`endif

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: a cycle-number based reference model
// checked every cycle, plus directed vectors with literal expected values.
`timescale 1ns/1ps
module tb_md_unit_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  e_md_op = 4'd0;
  logic        e_valid = 1'b0;
  logic [31:0] e_rs_val = 32'd0;
  logic [31:0] e_rt_val = 32'd0;
  logic        d_is_md = 1'b0;
  logic        busy, e_start, stall_md;
  logic [31:0] md_out, hi, lo;

  always #5 clk = ~clk;

  md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .e_md_op(e_md_op), .e_valid(e_valid),
    .e_rs_val(e_rs_val), .e_rt_val(e_rt_val), .d_is_md(d_is_md),
    .busy(busy), .e_start(e_start), .stall_md(stall_md), .md_out(md_out),
    .hi(hi), .lo(lo)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi, m_lo;
  bit          m_pend, m_wr;
  logic [63:0] m_res;
  int          m_cyc, m_commit;

  function automatic bit tb_is_start(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MD_MADD_EN
    if (op >= 4'd9 && op <= 4'd12) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [63:0] tb_result(input logic [3:0] op, input logic [31:0] rs,
                                            input logic [31:0] rt, input logic [63:0] acc);
    longint a, b;
    longint unsigned ua, ub;
    a  = longint'($signed(rs));
    b  = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    case (op)
      4'd1:  return a * b;
      4'd2:  return ua * ub;
      4'd3:  return {32'(a % b), 32'(a / b)};
      4'd4:  return {32'(ua % ub), 32'(ua / ub)};
      4'd9:  return acc + 64'(a * b);
      4'd10: return acc + 64'(ua * ub);
      4'd11: return acc - 64'(a * b);
      4'd12: return acc - 64'(ua * ub);
      default: return acc;
    endcase
  endfunction

  // Model: a start at edge E commits at edge E+N; nothing else happens while pending.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_pend <= 1'b0; m_cyc <= 0; m_commit <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_pend) begin
        if (m_cyc + 1 == m_commit) begin
          if (m_wr) begin m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; end
          m_pend <= 1'b0;
        end
      end else if (e_valid) begin
        if (tb_is_start(e_md_op)) begin
          m_pend   <= 1'b1;
          m_commit <= m_cyc + 1 + ((e_md_op == 4'd3 || e_md_op == 4'd4) ? DIV_N : MULT_N);
          m_wr     <= !((e_md_op == 4'd3 || e_md_op == 4'd4) && e_rt_val == 32'd0);
          if (!((e_md_op == 4'd3 || e_md_op == 4'd4) && e_rt_val == 32'd0))
            m_res <= tb_result(e_md_op, e_rs_val, e_rt_val, {m_hi, m_lo});
        end else if (e_md_op == 4'd7) m_hi <= e_rs_val;
        else if (e_md_op == 4'd8) m_lo <= e_rs_val;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_pend));
      chk("e_start", 32'(e_start), 32'(e_valid && tb_is_start(e_md_op)));
      chk("stall_md", 32'(stall_md), 32'(d_is_md && (m_pend || (e_valid && tb_is_start(e_md_op)))));
      chk("md_out", md_out, (e_md_op == 4'd5) ? m_hi : (e_md_op == 4'd6) ? m_lo : 32'd0);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic v, input logic dmd);
    e_md_op = op; e_rs_val = rs; e_rt_val = rt; e_valid = v; d_is_md = dmd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    drive(op, rs, rt, 1'b1, 1'b0);
    step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Count busy cycles after a start; bounded so a stuck unit shows as a wrong count.
  task automatic wait_busy(input string name, input int exp_n);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0 || i >= 3) break;
    end
    chk(name, 32'(n), 32'(exp_n));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    step();
    reset = 1'b0;
    chk_en = 1'b1;
    step();

    // mult -2 * 3
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_busy("mult_busy_cycles", 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    drive(4'd5, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mfhi_out", md_out, 32'hFFFF_FFFF);
    step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // divu 100 / 7
    issue(4'd4, 32'd100, 32'd7);
    wait_busy("divu_busy_cycles", 10);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // div -7 / 2
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_busy("div_busy_cycles", 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divide by zero leaves preset HI/LO
    issue(4'd7, 32'h11, 32'd0);
    issue(4'd8, 32'h22, 32'd0);
    issue(4'd3, 32'd1234, 32'd0);
    wait_busy("div0_busy_cycles", 10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // most-negative / -1
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy("divovf_busy_cycles", 10);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    // multu with an MD op waiting in D
    drive(4'd2, 32'd7, 32'd6, 1'b1, 1'b1);
    @(negedge clk);
    chk("stall_start", 32'(stall_md), 32'd1);
    step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall_md) n++;
      else break;
    end
    chk("stall_busy_cycles", 32'(n), 32'd5);
    chk("stall_after_commit", 32'(stall_md), 32'd0);
    step();
    drive(4'd6, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mflo_out", md_out, 32'd42);
    step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // async reset during busy cycle 3 of a div
    issue(4'd4, 32'd50, 32'd3);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    step();
    reset = 1'b0;
    repeat (14) @(negedge clk);
    chk("arst_no_commit_busy", 32'(busy), 32'd0);
    chk("arst_no_commit_hi", hi, 32'd0);
    chk("arst_no_commit_lo", lo, 32'd0);
    step();

    // madd {0,0xFFFFFFFF} + 1*1
    issue(4'd7, 32'd0, 32'd0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd0);
    drive(4'd9, 32'd1, 32'd1, 1'b1, 1'b0);
    @(negedge clk);
`ifdef MD_MADD_EN
    chk("madd_start", 32'(e_start), 32'd1);
    step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_busy("madd_busy_cycles", 5);
    chk("madd_hi", hi, 32'd1);
    chk("madd_lo", lo, 32'd0);
`else
    chk("madd_start", 32'(e_start), 32'd0);
    step();
    drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_busy("madd_busy_cycles", 0);
    chk("madd_hi", hi, 32'd0);
    chk("madd_lo", lo, 32'hFFFF_FFFF);
`endif

    repeat (2) step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
